// File: rtl/btod_req_bridge_if.sv
// Stream and req/ack bundle between the bridge and its neighbours:
// command stream in, btod request port out, response stream out.
interface btod_req_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ACK_W  = 16
);
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [DATA_W-1:0] cmd_data;
  logic              btod_req;
  logic [DATA_W-1:0] btod_data;
  logic              btod_ack;
  logic [ACK_W-1:0]  btod_ack_data;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [ACK_W-1:0]  rsp_data;

  modport master (
    output cmd_vld, cmd_data,
    output btod_ack, btod_ack_data,
    output rsp_rdy,
    input  cmd_rdy, btod_req, btod_data,
    input  rsp_vld, rsp_data
  );

  modport slave (
    input  cmd_vld, cmd_data,
    input  btod_ack, btod_ack_data,
    input  rsp_rdy,
    output cmd_rdy, btod_req, btod_data,
    output rsp_vld, rsp_data
  );
endinterface

// File: rtl/btod_req_bridge.sv
// Command FIFO feeding blockB's btod req/ack port with one request
// outstanding; the ack payload comes back on a response stream.
module btod_req_bridge #(
  parameter int DATA_W  = 32,
  parameter int ACK_W   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  btod_req_bridge_if.slave      bus,
  output logic                  timeout_err,
  input  logic                  err_clr,
  output logic [15:0]           done_cnt,
  output logic [$clog2(DEPTH):0] fifo_lvl
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       lvl, lvl_nxt;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic [ACK_W-1:0]  rsp_data_q, rsp_data_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic              err_q, err_d;
  logic [15:0]       done_q, done_d;
  logic              push, pop;
  logic              ack_hit, rsp_hs;
  logic              tmo_hit;

  assign lvl     = wr_ptr_q - rd_ptr_q;
  assign push    = bus.cmd_vld && cmd_rdy_q;
  assign pop     = (state_q == S_IDLE)
                && (lvl != '0);
  assign ack_hit = (state_q == S_REQ)
                && bus.btod_ack;
  assign rsp_hs  = (state_q == S_RSP)
                && bus.rsp_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pop)     state_d = S_REQ;
      S_REQ:   if (ack_hit) state_d = S_RSP;
      S_RSP:   if (rsp_hs)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
    lvl_nxt    = wr_ptr_d - rd_ptr_d;
    cmd_rdy_d  = (lvl_nxt != FULL);
    req_d      = req_q;
    data_d     = data_q;
    rsp_vld_d  = rsp_vld_q;
    rsp_data_d = rsp_data_q;
    done_d     = done_q;
    wait_d     = wait_q;
    if (state_q == S_REQ && wait_q != TMAX)
      wait_d = wait_q + TW'(1);
    unique case (1'b1)
      pop: begin
        req_d  = 1'b1;
        data_d = mem_q[rd_ptr_q[AW-1:0]];
        wait_d = '0;
      end
      ack_hit: begin
        req_d      = 1'b0;
        rsp_vld_d  = 1'b1;
        rsp_data_d = bus.btod_ack_data;
        done_d     = done_q + 16'd1;
      end
      rsp_hs: rsp_vld_d = 1'b0;
      default: ;
    endcase
    // Fires on the edge that completes TIMEOUT cycles in REQ.
    tmo_hit = (TIMEOUT != 0)
           && (state_q == S_REQ)
           && !bus.btod_ack
           && (wait_d == TMAX);
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (tmo_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cmd_rdy_q  <= 1'b0;
      req_q      <= 1'b0;
      data_q     <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cmd_rdy_q  <= cmd_rdy_d;
      req_q      <= req_d;
      data_q     <= data_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.cmd_data;
    end
  end

  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.btod_req  = req_q;
  assign bus.btod_data = data_q;
  assign bus.rsp_vld   = rsp_vld_q;
  assign bus.rsp_data  = rsp_data_q;
  assign timeout_err   = err_q;
  assign done_cnt      = done_q;
  assign fifo_lvl      = lvl;
endmodule
